// File: rtl/sipo_8bit_rx_if.sv
// Purpose: serial-in / parallel-out link bundle between a bit source and the receiver.
// Latency: none, wires only.
// Backpressure: dout_ready from the consumer; a word that cannot be held raises overrun.
interface sipo_8bit_rx_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic             sin;
    logic             sin_valid;
    logic             sync;
    logic             dout_ready;
    logic             overrun_clr;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             overrun;
    logic [CW-1:0]    bit_cnt;

    // Bit source / consumer side
    modport master (
        output sin, sin_valid, sync, dout_ready, overrun_clr,
        input  dout, dout_valid, overrun, bit_cnt
    );

    // Receiver side
    modport slave (
        input  sin, sin_valid, sync, dout_ready, overrun_clr,
        output dout, dout_valid, overrun, bit_cnt
    );
endinterface

// File: rtl/sipo_8bit_rx.sv
// Purpose: assemble WIDTH-bit words from a serial bit stream, MSB or LSB first.
// Latency: word registered on the edge that samples its last bit.
// Backpressure: one-word holding register; a completed word arriving while full and not consumed is dropped and flags overrun.
module sipo_8bit_rx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    sipo_8bit_rx_if.slave       bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_e;

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] sh_nxt;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    hold_state_e      state_q, state_d;
    logic             ov_q, ov_d;
    logic             word_done;
    logic             drop;

    // Shift path and bit counter; sync restarts the word, the bit that rides with it is bit 0
    always_comb begin
        sh_nxt    = MSB_FIRST ? {sh_q[WIDTH-2:0], bus.sin} : {bus.sin, sh_q[WIDTH-1:1]};
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
        if (bus.sin_valid) begin
            sh_d = sh_nxt;
            if (bus.sync) begin
                cnt_d = CW'(1);
            end else if (cnt_q == LAST) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (bus.sync) begin
            cnt_d = '0;
        end
    end

    // Holding register: accept into EMPTY, replace on same-cycle consume, drop when blocked
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        drop    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (word_done) begin
                    dout_d  = sh_nxt;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (word_done) begin
                    if (bus.dout_ready) begin
                        dout_d = sh_nxt;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (bus.dout_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Sticky overrun; a new drop beats a simultaneous clear
    always_comb begin
        ov_d = ov_q;
        if (drop) begin
            ov_d = 1'b1;
        end else if (bus.overrun_clr) begin
            ov_d = 1'b0;
        end
    end

    // State registers, all cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q    <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            state_q <= EMPTY;
            ov_q    <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = (state_q == FULL);
    assign bus.overrun    = ov_q;
    assign bus.bit_cnt    = cnt_q;
endmodule

// File: tb/tb_sipo_8bit_rx.sv
// Purpose: scoreboard bench driving an MSB-first and an LSB-first receiver from one bit stream.
// Latency: expects each word on dout from the negedge after its last bit's edge.
// Backpressure: dout_ready toggled directed and at random; drops predicted by the model.
module tb_sipo_8bit_rx;
    localparam int W = 8;

    logic clk;
    logic rst_n;

    sipo_8bit_rx_if #(.WIDTH(W)) bus0();
    sipo_8bit_rx_if #(.WIDTH(W)) bus1();

    sipo_8bit_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst_n(rst_n), .bus(bus0));
    sipo_8bit_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus1.sin         = bus0.sin;
    assign bus1.sin_valid   = bus0.sin_valid;
    assign bus1.sync        = bus0.sync;
    assign bus1.dout_ready  = bus0.dout_ready;
    assign bus1.overrun_clr = bus0.overrun_clr;

    int checks = 0;
    int errors = 0;

    // Reference model: words as lists of received bits
    logic [W-1:0] q_msb[$];
    logic [W-1:0] q_lsb[$];
    bit           m_bits[$];
    bit           m_full;
    bit           m_ov;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        q_msb.delete();
        q_lsb.delete();
        m_full = 1'b0;
        m_ov   = 1'b0;
    endtask

    task automatic model_update(input bit v, input bit s, input bit sy, input bit rdy, input bit clr);
        bit           done;
        bit           ov_set;
        logic [W-1:0] wm;
        logic [W-1:0] wl;
        done   = 1'b0;
        ov_set = 1'b0;
        wm     = '0;
        wl     = '0;
        if (v) begin
            if (sy) m_bits.delete();
            m_bits.push_back(s);
            if (m_bits.size() == W) begin
                for (int i = 0; i < W; i++) begin
                    wm[W-1-i] = m_bits[i];
                    wl[i]     = m_bits[i];
                end
                done = 1'b1;
                m_bits.delete();
            end
        end else if (sy) begin
            m_bits.delete();
        end
        if (done) begin
            if (!m_full || rdy) begin
                m_full = 1'b1;
                q_msb.push_back(wm);
                q_lsb.push_back(wl);
            end else begin
                ov_set = 1'b1;
            end
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end
        if (ov_set) m_ov = 1'b1;
        else if (clr) m_ov = 1'b0;
    endtask

    // One clock of stimulus; the model commits just after the edge it describes
    task automatic step(input bit v, input bit s, input bit sy, input bit rdy, input bit clr);
        bus0.sin_valid   = v;
        bus0.sin         = s;
        bus0.sync        = sy;
        bus0.dout_ready  = rdy;
        bus0.overrun_clr = clr;
        @(posedge clk);
        #1;
        model_update(v, s, sy, rdy, clr);
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit last_rdy, input int maxgap);
        logic [W-1:0] wv;
        wv = w;
        for (int i = W - 1; i >= 0; i--) begin
            repeat ($urandom_range(0, maxgap)) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
            step(1'b1, wv[i], 1'b0, (i == 0) ? last_rdy : rdy, 1'b0);
        end
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_dout_msb",  int'(bus0.dout), 0);
        check("rst_dout_lsb",  int'(bus1.dout), 0);
        check("rst_valid",     int'(bus0.dout_valid | bus1.dout_valid), 0);
        check("rst_overrun",   int'(bus0.overrun | bus1.overrun), 0);
        check("rst_bit_cnt",   int'(bus0.bit_cnt), 0);
        model_reset();
        rst_n = 1'b1;
    endtask

    // Monitor: per-cycle status against the model, words popped when newly presented
    bit           pv0, ph0, pv1, ph1;
    logic [W-1:0] held0, held1, e;
    always @(negedge clk) begin
        check("valid_msb",   int'(bus0.dout_valid), int'(m_full));
        check("valid_lsb",   int'(bus1.dout_valid), int'(m_full));
        check("overrun_msb", int'(bus0.overrun), int'(m_ov));
        check("overrun_lsb", int'(bus1.overrun), int'(m_ov));
        check("bit_cnt_msb", int'(bus0.bit_cnt), m_bits.size());
        check("bit_cnt_lsb", int'(bus1.bit_cnt), m_bits.size());
        if (bus0.dout_valid && (!pv0 || ph0)) begin
            checks++;
            if (q_msb.size() == 0) begin
                errors++;
                $display("FAIL word_msb unexpected dout=%0h with empty scoreboard", bus0.dout);
            end else begin
                e = q_msb.pop_front();
                if (bus0.dout != e) begin
                    errors++;
                    $display("FAIL word_msb actual=%0h expected=%0h at %0t", bus0.dout, e, $time);
                end
            end
            held0 = bus0.dout;
        end else if (bus0.dout_valid) begin
            check("hold_msb", int'(bus0.dout), int'(held0));
        end
        if (bus1.dout_valid && (!pv1 || ph1)) begin
            checks++;
            if (q_lsb.size() == 0) begin
                errors++;
                $display("FAIL word_lsb unexpected dout=%0h with empty scoreboard", bus1.dout);
            end else begin
                e = q_lsb.pop_front();
                if (bus1.dout != e) begin
                    errors++;
                    $display("FAIL word_lsb actual=%0h expected=%0h at %0t", bus1.dout, e, $time);
                end
            end
            held1 = bus1.dout;
        end else if (bus1.dout_valid) begin
            check("hold_lsb", int'(bus1.dout), int'(held1));
        end
        pv0 = bus0.dout_valid;
        ph0 = bus0.dout_valid && bus0.dout_ready;
        pv1 = bus1.dout_valid;
        ph1 = bus1.dout_valid && bus1.dout_ready;
    end

    logic [W-1:0] c3;
    logic [W-1:0] pat;

    initial begin
        rst_n            = 1'b0;
        bus0.sin         = 1'b0;
        bus0.sin_valid   = 1'b0;
        bus0.sync        = 1'b0;
        bus0.dout_ready  = 1'b0;
        bus0.overrun_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_dout",    int'(bus0.dout), 0);
        check("reset_valid",   int'(bus0.dout_valid), 0);
        check("reset_overrun", int'(bus0.overrun), 0);
        check("reset_bit_cnt", int'(bus0.bit_cnt), 0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // First word with no consumer: bit_cnt walks 1..7 then wraps
        pat = 8'hA9;
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b1, pat[i], 1'b0, 1'b0, 1'b0);
            check("cnt_walk", int'(bus0.bit_cnt), (W - i) % W);
        end
        check("first_word", int'(bus0.dout), 8'hA9);
        check("first_valid", int'(bus0.dout_valid), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back at full rate, then with gaps
        send_word(8'hA9, 1'b1, 1'b1, 0);
        send_word(8'h3C, 1'b1, 1'b1, 0);
        send_word(8'hA9, 1'b1, 1'b1, 3);
        send_word(8'h3C, 1'b1, 1'b1, 3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Backpressure and overrun
        send_word(8'hA9, 1'b0, 1'b0, 0);
        send_word(8'h55, 1'b0, 1'b0, 0);
        check("bp_dout", int'(bus0.dout), 8'hA9);
        check("bp_overrun", int'(bus0.overrun), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("bp_clr", int'(bus0.overrun), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("bp_drain", int'(bus0.dout_valid), 0);

        // Consume and complete on the same edge
        send_word(8'hA9, 1'b0, 1'b0, 0);
        send_word(8'hF0, 1'b0, 1'b1, 0);
        check("coll_dout", int'(bus0.dout), 8'hF0);
        check("coll_valid", int'(bus0.dout_valid), 1);
        check("coll_overrun", int'(bus0.overrun), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Resync after a partial word
        repeat (5) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
        c3 = 8'hC3;
        step(1'b1, c3[7], 1'b1, 1'b1, 1'b0);
        check("sync_cnt", int'(bus0.bit_cnt), 1);
        for (int i = W - 2; i >= 0; i--) step(1'b1, c3[i], 1'b0, 1'b0, 1'b0);
        check("sync_dout", int'(bus0.dout), 8'hC3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a word, then a fresh word
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        send_word(8'h81, 1'b0, 1'b0, 0);
        check("post_rst_dout", int'(bus0.dout), 8'h81);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        pat = 8'h95;
        for (int i = W - 1; i >= 0; i--) step(1'b1, pat[i], 1'b0, 1'b0, 1'b0);
        check("lsb_first_dout", int'(bus1.dout), 8'hA9);
        check("msb_same_bits",  int'(bus0.dout), 8'h95);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random traffic with sync, gaps, backpressure and clears
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0));
        end
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("sb_empty_msb", q_msb.size(), 0);
        check("sb_empty_lsb", q_lsb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
